// File: rtl/fft_pkg.sv
// Shared FFT constants and state type.
// Used by the FFT core, decoder and result streamer.
package fft_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int N         = 9;
  localparam int FFT_SIZE  = 512;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } fft_state_t;

endpackage

// File: rtl/fft_stream_bitrev.sv
// Combinational N-bit bit reversal.
// Maps a natural bin index to its RAM slot.
module bitrev #(
  parameter int W = 9
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < W; i++) begin
      dout[i] = din[W-1-i];
    end
  end

endmodule

// File: rtl/fft_stream.sv
// Streams one finished FFT frame out of the
// external result RAM in natural bin order.
module fft_stream #(
  parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
  parameter int N         = fft_pkg::N,
  parameter int FFT_SIZE  = fft_pkg::FFT_SIZE,
  parameter int BIT_REV   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_complete,
  output logic [N-1:0]           rd_addr,
  output logic                   rd_en,
  input  logic [2*BIT_WIDTH-1:0] rd_data,
  output logic                   fft_done,
  output logic [2*BIT_WIDTH-1:0] fft_result,
  output logic [N-1:0]           bin_idx,
  output logic                   frame_last,
  output logic                   busy,
  output logic                   overrun
);

  import fft_pkg::*;

  localparam logic [N:0] CNT_END  = (N+1)'(FFT_SIZE);
  localparam logic [N:0] OUT_LAST = (N+1)'(FFT_SIZE - 1);
  localparam logic [N:0] CNT_ONE  = (N+1)'(1);

  fft_state_t       state;
  logic [N:0]       cnt;
  logic [N:0]       out_cnt;
  logic             rd_valid;
  logic [N-1:0]     rev;
  logic [N-1:0]     nxt_addr;

  bitrev #(
    .W(N)
  ) u_bitrev (
    .din  (cnt[N-1:0]),
    .dout (rev)
  );

  assign nxt_addr = (BIT_REV != 0) ? rev : cnt[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      out_cnt    <= '0;
      rd_valid   <= 1'b0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      fft_done   <= 1'b0;
      fft_result <= '0;
      bin_idx    <= '0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // rd_valid marks the cycle rd_data is valid
      rd_valid <= rd_en;
      fft_done <= rd_valid;
      if (rd_valid) begin
        fft_result <= rd_data;
        bin_idx    <= out_cnt[N-1:0];
        frame_last <= (out_cnt == OUT_LAST);
        out_cnt    <= out_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          cnt     <= '0;
          out_cnt <= '0;
          if (fft_complete) begin
            state   <= READ;
            rd_addr <= nxt_addr;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            cnt     <= CNT_ONE;
          end
        end
        READ: begin
          if (fft_complete) overrun <= 1'b1;
          if (cnt == CNT_END) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= nxt_addr;
            cnt     <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (fft_complete) overrun <= 1'b1;
          if (fft_done && frame_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream.sv
// Directed bench for fft_stream: natural and
// bit-reversed frames, overrun, resets.
module tb_fft_stream;

  logic        clk;
  logic        reset;
  logic        fc0, fc1;
  logic [8:0]  rd_addr0, rd_addr1;
  logic        rd_en0, rd_en1;
  logic [31:0] rd_data0, rd_data1;
  logic        fft_done0, fft_done1;
  logic [31:0] fft_result0, fft_result1;
  logic [8:0]  bin_idx0, bin_idx1;
  logic        frame_last0, frame_last1;
  logic        busy0, busy1;
  logic        overrun0, overrun1;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc = 0;
  int done_cnt, data_err, seq_err;
  int last_cnt, last_err;
  int first_done, last_done, f2_done;
  int done1_cnt;
  int e0, e1;
  logic [8:0]  exp_bin;
  logic [31:0] bin1_res;

  fft_stream #(
    .BIT_WIDTH(16), .N(9),
    .FFT_SIZE(512), .BIT_REV(0)
  ) dut0 (
    .clk          (clk),
    .reset        (reset),
    .fft_complete (fc0),
    .rd_addr      (rd_addr0),
    .rd_en        (rd_en0),
    .rd_data      (rd_data0),
    .fft_done     (fft_done0),
    .fft_result   (fft_result0),
    .bin_idx      (bin_idx0),
    .frame_last   (frame_last0),
    .busy         (busy0),
    .overrun      (overrun0)
  );

  fft_stream #(
    .BIT_WIDTH(16), .N(9),
    .FFT_SIZE(512), .BIT_REV(1)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .fft_complete (fc1),
    .rd_addr      (rd_addr1),
    .rd_en        (rd_en1),
    .rd_data      (rd_data1),
    .fft_done     (fft_done1),
    .fft_result   (fft_result1),
    .bin_idx      (bin_idx1),
    .frame_last   (frame_last1),
    .busy         (busy1),
    .overrun      (overrun1)
  );

  function automatic logic [31:0] word(
    input logic [8:0] k
  );
    logic [15:0] w;
    w = {7'd0, k};
    return {w, ~w};
  endfunction

  // RAM word k holds {k, ~k}
  always_ff @(posedge clk) begin
    if (rd_en0) rd_data0 <= word(rd_addr0);
    if (rd_en1) rd_data1 <= word(rd_addr1);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    done_cnt   = 0;
    data_err   = 0;
    seq_err    = 0;
    last_cnt   = 0;
    last_err   = 0;
    first_done = -1;
    last_done  = -1;
    f2_done    = -1;
    exp_bin    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
    if (fft_done0) begin
      if (fft_result0 !== word(exp_bin))
        data_err++;
      if (bin_idx0 !== exp_bin) seq_err++;
      if (frame_last0 !== (exp_bin == 9'd511))
        last_err++;
      if (frame_last0) last_cnt++;
      exp_bin = exp_bin + 9'd1;
      done_cnt++;
      if (first_done < 0) first_done = ncyc;
      if (done_cnt == 513) f2_done = ncyc;
      last_done = ncyc;
    end
    if (fft_done1) begin
      if (done1_cnt == 1) bin1_res = fft_result1;
      done1_cnt++;
    end
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 700 && busy0; i++)
      cyc();
    chk("idle0_timeout", 64'(busy0), 64'd0);
  endtask

  task automatic to_bin0(input logic [8:0] b);
    for (int i = 0; i < 700; i++) begin
      if (fft_done0 && bin_idx0 == b) break;
      cyc();
    end
    chk("reach_bin", 64'(bin_idx0), 64'(b));
  endtask

  initial begin
    reset = 1'b1;
    fc0 = 1'b0;
    fc1 = 1'b0;
    done1_cnt = 0;
    bin1_res = '0;
    clr();
    cyc();
    cyc();
    chk("rst_rd_en", 64'(rd_en0), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr0), 64'd0);
    chk("rst_done", 64'(fft_done0), 64'd0);
    chk("rst_result", 64'(fft_result0), 64'd0);
    chk("rst_bin", 64'(bin_idx0), 64'd0);
    chk("rst_last", 64'(frame_last0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_ovr", 64'(overrun0), 64'd0);
    reset = 1'b0;
    cyc();

    // single natural-order frame
    clr();
    fc0 = 1'b1;
    e0 = ncyc + 1;
    cyc();
    fc0 = 1'b0;
    chk("f1_rd_en", 64'(rd_en0), 64'd1);
    chk("f1_addr0", 64'(rd_addr0), 64'd0);
    chk("f1_busy", 64'(busy0), 64'd1);
    cyc();
    chk("f1_addr1", 64'(rd_addr0), 64'd1);
    wait_idle0();
    chk("f1_busy_fall", 64'(ncyc), 64'(e0 + 514));
    chk("f1_count", 64'(done_cnt), 64'd512);
    chk("f1_first", 64'(first_done), 64'(e0 + 2));
    chk("f1_lastdn", 64'(last_done), 64'(e0 + 513));
    chk("f1_data", 64'(data_err), 64'd0);
    chk("f1_seq", 64'(seq_err), 64'd0);
    chk("f1_lastflag", 64'(last_err), 64'd0);
    chk("f1_lastcnt", 64'(last_cnt), 64'd1);
    chk("f1_rd_en_off", 64'(rd_en0), 64'd0);
    chk("f1_hold_res", 64'(fft_result0),
        64'(word(9'd511)));
    chk("f1_hold_bin", 64'(bin_idx0), 64'd511);

    // bit-reversed frame
    done1_cnt = 0;
    fc1 = 1'b1;
    cyc();
    fc1 = 1'b0;
    chk("br_a0", 64'(rd_addr1), 64'd0);
    cyc();
    chk("br_a1", 64'(rd_addr1), 64'd256);
    cyc();
    chk("br_a2", 64'(rd_addr1), 64'd128);
    cyc();
    chk("br_a3", 64'(rd_addr1), 64'd384);
    for (int i = 0; i < 700 && busy1; i++)
      cyc();
    chk("br_idle", 64'(busy1), 64'd0);
    chk("br_count", 64'(done1_cnt), 64'd512);
    chk("br_bin1", 64'(bin1_res),
        64'(word(9'd256)));

    // overrun: pulse during bin 100
    clr();
    fc0 = 1'b1;
    cyc();
    fc0 = 1'b0;
    to_bin0(9'd100);
    fc0 = 1'b1;
    cyc();
    fc0 = 1'b0;
    wait_idle0();
    chk("ov_count", 64'(done_cnt), 64'd512);
    chk("ov_data", 64'(data_err), 64'd0);
    chk("ov_flag", 64'(overrun0), 64'd1);
    clr();
    repeat (20) cyc();
    chk("ov_noframe", 64'(done_cnt), 64'd0);
    chk("ov_busy", 64'(busy0), 64'd0);
    chk("ov_sticky", 64'(overrun0), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("ov_clear", 64'(overrun0), 64'd0);

    // back-to-back frames
    clr();
    fc0 = 1'b1;
    cyc();
    fc0 = 1'b0;
    wait_idle0();
    fc0 = 1'b1;
    e1 = ncyc + 1;
    cyc();
    fc0 = 1'b0;
    wait_idle0();
    chk("bb_count", 64'(done_cnt), 64'd1024);
    chk("bb_first2", 64'(f2_done), 64'(e1 + 2));
    chk("bb_last2", 64'(last_done), 64'(e1 + 513));
    chk("bb_seq", 64'(seq_err), 64'd0);
    chk("bb_data", 64'(data_err), 64'd0);
    chk("bb_lastcnt", 64'(last_cnt), 64'd2);
    chk("bb_ovr", 64'(overrun0), 64'd0);

    // reset in the middle of a frame
    clr();
    fc0 = 1'b1;
    cyc();
    fc0 = 1'b0;
    to_bin0(9'd300);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rm_rd_en", 64'(rd_en0), 64'd0);
    chk("rm_addr", 64'(rd_addr0), 64'd0);
    chk("rm_done", 64'(fft_done0), 64'd0);
    chk("rm_result", 64'(fft_result0), 64'd0);
    chk("rm_bin", 64'(bin_idx0), 64'd0);
    chk("rm_busy", 64'(busy0), 64'd0);
    clr();
    repeat (30) cyc();
    chk("rm_quiet", 64'(done_cnt), 64'd0);
    clr();
    fc0 = 1'b1;
    e0 = ncyc + 1;
    cyc();
    fc0 = 1'b0;
    wait_idle0();
    chk("rm_count", 64'(done_cnt), 64'd512);
    chk("rm_first", 64'(first_done), 64'(e0 + 2));
    chk("rm_seq", 64'(seq_err), 64'd0);
    chk("rm_data", 64'(data_err), 64'd0);

    // reset wins over a coincident pulse
    reset = 1'b1;
    fc0 = 1'b1;
    cyc();
    reset = 1'b0;
    fc0 = 1'b0;
    chk("rc_busy", 64'(busy0), 64'd0);
    chk("rc_rd_en", 64'(rd_en0), 64'd0);
    clr();
    repeat (10) cyc();
    chk("rc_busy2", 64'(busy0), 64'd0);
    chk("rc_quiet", 64'(done_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
